register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter RegWidth, default 16, width in bits of each register and data port, SHALL be supported.
REQ-002 Parameter AddrBits, default 3, address width, SHALL be supported; register count = 2**AddrBits (8 by default).
REQ-003 CLK  input  1  sole clock; all state changes on rising edge except reset.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 WriteEN  input  1  write enable, sampled on rising CLK.
REQ-006 WriteAddr  input  AddrBits  register index to write.
REQ-007 WriteData  input  RegWidth  value to write (two's-complement or raw bits, no interpretation).
REQ-008 ReadAddr1  input  AddrBits  index for read port 1.
REQ-009 ReadData1  output  RegWidth  contents of register[ReadAddr1].
REQ-010 ReadAddr2  input  AddrBits  index for read port 2.
REQ-011 ReadData2  output  RegWidth  contents of register[ReadAddr2].
REQ-012 inr  input  AddrBits  index for debug/observation read port.
REQ-013 out_value  output  RegWidth  contents of register[inr].

Function
REQ-014 Storage SHALL be 2**AddrBits registers of RegWidth bits each; all registers, including index 0, SHALL be general-purpose and writable.
REQ-015 On rising CLK with WriteEN=1 and RST=0, register[WriteAddr] SHALL take WriteData; no other register changes.
REQ-016 With WriteEN=0, no register SHALL change on a clock edge.
REQ-017 All three read ports SHALL be combinational (zero-cycle latency): output follows address and stored contents without waiting for a clock.
REQ-018 The three read ports SHALL be independent; any port may address any register, including the same register simultaneously.
REQ-019 Read of the register being written in the same cycle SHALL return the old value until the rising edge, then the new value; no internal write-to-read bypass.
REQ-020 Written value SHALL be stored bit-exact at full RegWidth; no sign extension, truncation or saturation.
REQ-021 Addresses cover the full range exactly; no out-of-range case exists.

Reset
REQ-022 RST=1 SHALL immediately, without a clock edge, clear every register to 0, so ReadData1, ReadData2 and out_value read 0 regardless of address.
REQ-023 While RST=1, writes SHALL be blocked even if WriteEN=1 at a rising edge.
REQ-024 After RST deasserts, registers SHALL stay 0 until written; normal writes resume on the next rising edge with RST=0.
REQ-025 Reset asserted mid-operation (between writes) SHALL discard all prior contents.

Structure
REQ-026 Default values of RegWidth and AddrBits SHALL be defined as constants in the shared processor package and used as the parameter defaults.
REQ-027 The block SHALL be implemented as a single module with no sub-modules: an array of registers, one write-decode process and three combinational read multiplexers.

Verification
REQ-028 Reset then idle: pulse RST=1 -> all three outputs 0 for every address.
REQ-029 Writes: WriteEN=1; write r1=25, r2=99, r3=-40 on consecutive edges; WriteEN=0; ReadAddr1=1, ReadAddr2=2, inr=3 -> ReadData1=0x0019, ReadData2=0x0063, out_value=0xFFD8.
REQ-030 Write disabled: WriteEN=0, WriteAddr=1, WriteData=0x1234, clock several edges -> register 1 still reads 25.
REQ-031 Asynchronous reset: with the values from REQ-029 stored, raise RST away from a clock edge -> all outputs read 0 before the next rising edge; after release they stay 0.
REQ-032 Same-cycle read/write: ReadAddr1=WriteAddr=5, WriteData=0x00AA, WriteEN=1 -> ReadData1 shows the old value before the edge and 0x00AA after it; all three ports on address 5 agree.
REQ-033 Register 0 and top index: write r0=0x0001 and r7=0x8000 -> both read back exactly on all three ports.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared processor constants: default geometry of the general-purpose register file.
package register_file_pkg;

  localparam int unsigned DefaultRegWidth = 16;
  localparam int unsigned DefaultAddrBits = 3;

  localparam int unsigned DefaultRegCount = 2 ** DefaultAddrBits;

endpackage

// File: rtl/register_file.sv
// General-purpose register file: one synchronous write port, three combinational read ports
// (two operand ports plus one observation port), asynchronous active-high clear.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned RegWidth = DefaultRegWidth,
  parameter int unsigned AddrBits = DefaultAddrBits
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WriteEN,
  input  logic [AddrBits-1:0] WriteAddr,
  input  logic [RegWidth-1:0] WriteData,
  input  logic [AddrBits-1:0] ReadAddr1,
  output logic [RegWidth-1:0] ReadData1,
  input  logic [AddrBits-1:0] ReadAddr2,
  output logic [RegWidth-1:0] ReadData2,
  input  logic [AddrBits-1:0] inr,
  output logic [RegWidth-1:0] out_value
);

  localparam int unsigned RegCount = 2 ** AddrBits;

  logic [RegWidth-1:0] regFile [RegCount];

  // Reset clears every entry at once; register 0 is an ordinary writable register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RegCount; i++) begin
        regFile[i] <= '0;
      end
    end else if (WriteEN) begin
      regFile[WriteAddr] <= WriteData;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the old value until the edge.
  always_comb begin
    ReadData1 = regFile[ReadAddr1];
    ReadData2 = regFile[ReadAddr2];
    out_value = regFile[inr];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expected values.
module tb_register_file;

  logic        CLK;
  logic        RST;
  logic        WriteEN;
  logic [2:0]  WriteAddr;
  logic [15:0] WriteData;
  logic [2:0]  ReadAddr1;
  logic [15:0] ReadData1;
  logic [2:0]  ReadAddr2;
  logic [15:0] ReadData2;
  logic [2:0]  inr;
  logic [15:0] out_value;

  int nCompared;
  int nMismatched;

  register_file dut (
    .CLK       (CLK),
    .RST       (RST),
    .WriteEN   (WriteEN),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .ReadAddr1 (ReadAddr1),
    .ReadData1 (ReadData1),
    .ReadAddr2 (ReadAddr2),
    .ReadData2 (ReadData2),
    .inr       (inr),
    .out_value (out_value)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
    @(negedge CLK);
    WriteEN   = 1'b1;
    WriteAddr = addr;
    WriteData = data;
    @(posedge CLK);
    #1;
    WriteEN = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #3;
    for (int a = 0; a < 8; a++) begin
      ReadAddr1 = 3'(a);
      ReadAddr2 = 3'(a);
      inr       = 3'(a);
      #1;
      nCompared++;
      if (ReadData1 !== 16'h0 || ReadData2 !== 16'h0 || out_value !== 16'h0) begin
        nMismatched++;
        $display("FAIL reset_clear addr=%0d got %h/%h/%h want 0000/0000/0000",
                 a, ReadData1, ReadData2, out_value);
      end
    end
    // Write attempted while reset held must be blocked.
    @(negedge CLK);
    WriteEN   = 1'b1;
    WriteAddr = 3'd4;
    WriteData = 16'hBEEF;
    ReadAddr1 = 3'd4;
    @(posedge CLK);
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0) begin
      nMismatched++;
      $display("FAIL reset_blocks_write got %h want 0000", ReadData1);
    end
    @(negedge CLK);
    WriteEN = 1'b0;
    RST     = 1'b0;
    @(posedge CLK);
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0) begin
      nMismatched++;
      $display("FAIL reset_release_zero got %h want 0000", ReadData1);
    end
  endtask

  task automatic test_writes();
    write_reg(3'd1, 16'd25);
    write_reg(3'd2, 16'd99);
    write_reg(3'd3, 16'hFFD8);  // -40
    ReadAddr1 = 3'd1;
    ReadAddr2 = 3'd2;
    inr       = 3'd3;
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0019) begin
      nMismatched++;
      $display("FAIL write_r1 got %h want 0019", ReadData1);
    end
    nCompared++;
    if (ReadData2 !== 16'h0063) begin
      nMismatched++;
      $display("FAIL write_r2 got %h want 0063", ReadData2);
    end
    nCompared++;
    if (out_value !== 16'hFFD8) begin
      nMismatched++;
      $display("FAIL write_r3 got %h want ffd8", out_value);
    end
    // Neighbouring registers untouched.
    ReadAddr1 = 3'd0;
    ReadAddr2 = 3'd4;
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0 || ReadData2 !== 16'h0) begin
      nMismatched++;
      $display("FAIL write_isolation got %h/%h want 0000/0000", ReadData1, ReadData2);
    end
  endtask

  task automatic test_write_disabled();
    @(negedge CLK);
    WriteEN   = 1'b0;
    WriteAddr = 3'd1;
    WriteData = 16'h1234;
    ReadAddr1 = 3'd1;
    repeat (4) @(posedge CLK);
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0019) begin
      nMismatched++;
      $display("FAIL write_disabled got %h want 0019", ReadData1);
    end
  endtask

  task automatic test_async_reset();
    ReadAddr1 = 3'd1;
    ReadAddr2 = 3'd2;
    inr       = 3'd3;
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0 || ReadData2 !== 16'h0 || out_value !== 16'h0) begin
      nMismatched++;
      $display("FAIL async_reset got %h/%h/%h want 0000/0000/0000",
               ReadData1, ReadData2, out_value);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0 || ReadData2 !== 16'h0 || out_value !== 16'h0) begin
      nMismatched++;
      $display("FAIL async_reset_hold got %h/%h/%h want 0000/0000/0000",
               ReadData1, ReadData2, out_value);
    end
  endtask

  task automatic test_same_cycle();
    write_reg(3'd5, 16'h0055);
    @(negedge CLK);
    ReadAddr1 = 3'd5;
    ReadAddr2 = 3'd5;
    inr       = 3'd5;
    WriteAddr = 3'd5;
    WriteData = 16'h00AA;
    WriteEN   = 1'b1;
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0055) begin
      nMismatched++;
      $display("FAIL same_cycle_before got %h want 0055", ReadData1);
    end
    @(posedge CLK);
    #1;
    WriteEN = 1'b0;
    nCompared++;
    if (ReadData1 !== 16'h00AA || ReadData2 !== 16'h00AA || out_value !== 16'h00AA) begin
      nMismatched++;
      $display("FAIL same_cycle_after got %h/%h/%h want 00aa/00aa/00aa",
               ReadData1, ReadData2, out_value);
    end
  endtask

  task automatic test_boundaries();
    write_reg(3'd0, 16'h0001);
    write_reg(3'd7, 16'h8000);
    ReadAddr1 = 3'd0;
    ReadAddr2 = 3'd0;
    inr       = 3'd0;
    #1;
    nCompared++;
    if (ReadData1 !== 16'h0001 || ReadData2 !== 16'h0001 || out_value !== 16'h0001) begin
      nMismatched++;
      $display("FAIL reg0 got %h/%h/%h want 0001/0001/0001", ReadData1, ReadData2, out_value);
    end
    ReadAddr1 = 3'd7;
    ReadAddr2 = 3'd7;
    inr       = 3'd7;
    #1;
    nCompared++;
    if (ReadData1 !== 16'h8000 || ReadData2 !== 16'h8000 || out_value !== 16'h8000) begin
      nMismatched++;
      $display("FAIL reg7 got %h/%h/%h want 8000/8000/8000", ReadData1, ReadData2, out_value);
    end
    // Mixed addressing across ports at once.
    ReadAddr1 = 3'd7;
    ReadAddr2 = 3'd5;
    inr       = 3'd0;
    #1;
    nCompared++;
    if (ReadData1 !== 16'h8000 || ReadData2 !== 16'h00AA || out_value !== 16'h0001) begin
      nMismatched++;
      $display("FAIL mixed_ports got %h/%h/%h want 8000/00aa/0001",
               ReadData1, ReadData2, out_value);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    RST       = 1'b0;
    WriteEN   = 1'b0;
    WriteAddr = '0;
    WriteData = '0;
    ReadAddr1 = '0;
    ReadAddr2 = '0;
    inr       = '0;
    test_reset();
    test_writes();
    test_write_disabled();
    test_async_reset();
    test_same_cycle();
    test_boundaries();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
